// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the two-master MIPS bus arbiter.
// Grant selection for the idle-state arbitration decision lives here as well.
package mips_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } bus_req_t;

    // On a tie the master that did not own the bus last time wins.
    function automatic grant_e pick_grant(input logic i_pend, input logic d_pend,
                                          input grant_e last);
        grant_e g;
        if (i_pend && d_pend) begin
            if (last == GNT_I) g = GNT_D;
            else               g = GNT_I;
        end else if (d_pend) begin
            g = GNT_D;
        end else begin
            g = GNT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive stalled grant cycles; expired fires on the stall cycle that
// brings the count to TIMEOUT.
module bus_timeout_counter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    assign expired = enable && (count_q == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between a fetch and a data master,
// with registered bus strobes and a stall timeout that sets a sticky error.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_waitrequest,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_waitrequest,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              bus_error
);

    state_e   state_q;
    grant_e   last_q;
    bus_req_t bus_q;
    logic     bus_error_q;

    bus_req_t fetch_req;
    bus_req_t data_req;
    grant_e   pick;
    logic     i_pend;
    logic     d_pend;
    logic     start;
    logic     granted;
    logic     done;
    logic     stall;
    logic     expired;
    logic     i_ack;
    logic     d_ack;

    assign i_pend  = i_read;
    assign d_pend  = d_read | d_write;
    assign pick    = pick_grant(i_pend, d_pend, last_q);
    assign start   = (state_q == IDLE) && (i_pend || d_pend);
    assign granted = (state_q != IDLE);
    assign done    = granted && !waitrequest;
    assign stall   = granted && waitrequest;

    // A simultaneous read and write from the data master issues only the write.
    always_comb begin
        fetch_req       = '0;
        fetch_req.addr  = i_address;
        fetch_req.read  = 1'b1;
        fetch_req.be    = '1;
        data_req        = '0;
        data_req.addr   = d_address;
        data_req.read   = d_read & ~d_write;
        data_req.write  = d_write;
        data_req.wdata  = d_writedata;
        data_req.be     = d_byteenable;
    end

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable (stall),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= GNT_D;
            bus_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        last_q <= pick;
                        if (pick == GNT_I) begin
                            state_q <= GRANT_I;
                            bus_q   <= fetch_req;
                        end else begin
                            state_q <= GRANT_D;
                            bus_q   <= data_req;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done || expired) begin
                        state_q <= IDLE;
                        bus_q   <= '0;
                        if (expired) bus_error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bus_q   <= '0;
                end
            endcase
        end
    end

    // An abort acknowledges the owner with zero data so it can move on.
    assign i_ack = (state_q == GRANT_I) && (done || expired);
    assign d_ack = (state_q == GRANT_D) && (done || expired);

    assign i_waitrequest = !i_ack;
    assign d_waitrequest = !d_ack;
    assign i_readdata    = ((state_q == GRANT_I) && done) ? readdata : '0;
    assign d_readdata    = ((state_q == GRANT_D) && done) ? readdata : '0;

    assign address    = bus_q.addr;
    assign read       = bus_q.read;
    assign write      = bus_q.write;
    assign writedata  = bus_q.wdata;
    assign byteenable = bus_q.be;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of the arbiter.
module tb_mips_bus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_bus_arbiter #(
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_readdata   (i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_byteenable (d_byteenable),
        .d_readdata   (d_readdata),
        .d_waitrequest(d_waitrequest),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .bus_error    (bus_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner 0 = nobody, 1 = fetch, 2 = data; latched transaction fields.
    int          m_own;
    int          m_last;
    int          m_stall;
    logic        m_err;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic        m_rd;
    logic        m_wr;
    logic [3:0]  m_be;
    bit          e_idone;
    bit          e_ddone;
    int          glog[$];
    logic [31:0] mem[64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 2; m_stall = 0; m_err = 1'b0;
        m_addr = '0; m_wd = '0; m_rd = 1'b0; m_wr = 1'b0; m_be = '0;
    endtask

    task automatic compare_and_advance();
        bit          done;
        bit          abort;
        bit          ip;
        bit          dp;
        int          g;
        logic        e_iw;
        logic        e_dw;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
        if (!reset) model_reset();
        done  = (m_own != 0) && !waitrequest;
        abort = (m_own != 0) && waitrequest && (m_stall + 1 == TO);
        e_iw  = !((m_own == 1) && (done || abort));
        e_dw  = !((m_own == 2) && (done || abort));
        e_ir  = ((m_own == 1) && done) ? readdata : 32'h0;
        e_dr  = ((m_own == 2) && done) ? readdata : 32'h0;
        chk("address",       address,       (m_own != 0) ? m_addr : 32'h0);
        chk("read",          read,          (m_own != 0) ? m_rd : 1'b0);
        chk("write",         write,         (m_own != 0) ? m_wr : 1'b0);
        chk("writedata",     writedata,     (m_own != 0) ? m_wd : 32'h0);
        chk("byteenable",    byteenable,    (m_own != 0) ? m_be : 4'h0);
        chk("i_waitrequest", i_waitrequest, e_iw);
        chk("i_readdata",    i_readdata,    e_ir);
        chk("d_waitrequest", d_waitrequest, e_dw);
        chk("d_readdata",    d_readdata,    e_dr);
        chk("bus_error",     bus_error,     m_err);
        e_idone = reset && !e_iw;
        e_ddone = reset && !e_dw;
        if (reset && write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address[7:2]][b*8 +: 8] = writedata[b*8 +: 8];
        end
        if (reset) begin
            if (m_own != 0) begin
                if (done || abort) begin
                    m_own = 0;
                    if (abort) m_err = 1'b1;
                end else begin
                    m_stall++;
                end
            end else begin
                ip = i_read;
                dp = d_read || d_write;
                if (ip || dp) begin
                    if (ip && dp) g = (m_last == 1) ? 2 : 1;
                    else          g = ip ? 1 : 2;
                    m_own = g; m_last = g; m_stall = 0;
                    glog.push_back(g);
                    if (g == 1) begin
                        m_addr = i_address; m_rd = 1'b1; m_wr = 1'b0; m_wd = '0; m_be = 4'hF;
                    end else begin
                        m_addr = d_address; m_wr = d_write; m_rd = d_read && !d_write;
                        m_wd = d_writedata; m_be = d_byteenable;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt;
        int          rd_cyc;
        int          acks;
        int          moved;
        int          stalls;
        int          aborts;
        int          stuck;
        bit          fin;
        bit          i_act;
        bit          d_act;
        logic [31:0] got;
        for (int k = 0; k < 64; k++) mem[k] = '0;
        model_reset();
        reset = 1'b0; waitrequest = 1'b0; readdata = '0;
        idle_inputs();

        // Reset state
        step(); step();
        chk("rst_read", read, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_i_wait", i_waitrequest, 1'b1);
        reset = 1'b1;

        // Single fetch, no stall
        i_read = 1'b1; i_address = 32'hBFC0_0000; readdata = 32'h3C02_1234;
        step();
        chk("f_address", address, 32'hBFC0_0000);
        chk("f_read", read, 1'b1);
        chk("f_i_wait", i_waitrequest, 1'b0);
        chk("f_i_readdata", i_readdata, 32'h3C02_1234);
        step();
        i_read = 1'b0;
        #1;
        chk("f_read_drop", read, 1'b0);
        chk("f_i_wait_after", i_waitrequest, 1'b1);
        step();

        // Simultaneous fetch and data write after reset: fetch wins
        reset = 1'b0; step(); reset = 1'b1;
        glog.delete();
        i_read = 1'b1; i_address = 32'h0;
        d_write = 1'b1; d_address = 32'hBFC0_0010; d_writedata = 32'h3333_3333;
        d_byteenable = 4'hF;
        fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            step();
            if (e_idone) i_read = 1'b0;
            if (e_ddone) d_write = 1'b0;
            fin = !i_read && !d_write;
        end
        chk("tie_done", fin, 1'b1);
        chk("tie_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("tie_first", glog[0], 1);
            chk("tie_second", glog[1], 2);
        end
        chk("mem_word4", mem[4], 32'h3333_3333);

        // Sustained contention alternates I,D,I,D...
        glog.delete();
        i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
        for (int c = 0; c < 60 && glog.size() < 8; c++) step();
        chk("rr_grants", (glog.size() >= 8), 1'b1);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_order", glog[k], (k % 2 == 0) ? 1 : 2);
        idle_inputs();
        step(); step(); step();

        // Three stall cycles then completion
        i_read = 1'b1; i_address = 32'h100;
        rd_cyc = 0; acks = 0; moved = 0; stalls = 0; fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            waitrequest = (m_own != 0) && (stalls < 3);
            #1;
            if (read) begin
                rd_cyc++;
                if (address != 32'h100) moved++;
            end
            if (!i_waitrequest) acks++;
            if (m_own == 1 && waitrequest) stalls++;
            step();
            fin = e_idone;
        end
        i_read = 1'b0; waitrequest = 1'b0;
        chk("stall_read_cycles", rd_cyc, 4);
        chk("stall_acks", acks, 1);
        chk("stall_addr_moved", moved, 0);
        chk("stall_bus_error", bus_error, 1'b0);
        step();

        // Stuck slave aborts a data read on the TIMEOUT-th stall cycle
        d_read = 1'b1; d_address = 32'h40; waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
        cnt = 0; aborts = 0; got = 32'hFFFF_FFFF; fin = 1'b0;
        for (int c = 0; c < 30 && !fin; c++) begin
            #1;
            if (m_own == 2) cnt++;
            if (m_own == 2 && !d_waitrequest) begin
                aborts++;
                got = d_readdata;
            end
            step();
            fin = e_ddone;
        end
        d_read = 1'b0; waitrequest = 1'b0;
        chk("to_grant_cycles", cnt, TO);
        chk("to_aborts", aborts, 1);
        chk("to_d_readdata", got, 32'h0);
        chk("to_bus_error", bus_error, 1'b1);
        i_read = 1'b1; i_address = 32'h200; readdata = 32'h1234_5678;
        got = '0; fin = 1'b0;
        for (int c = 0; c < 10 && !fin; c++) begin
            #1;
            if (!i_waitrequest) got = i_readdata;
            step();
            fin = e_idone;
        end
        i_read = 1'b0;
        chk("post_to_fetch", got, 32'h1234_5678);
        chk("post_to_sticky", bus_error, 1'b1);
        step();

        // Reset mid-grant drops strobes without a clock edge
        i_read = 1'b1; i_address = 32'h300; waitrequest = 1'b1;
        step();
        chk("mid_read_before", read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_read", read, 1'b0);
        chk("mid_write", write, 1'b0);
        chk("mid_i_wait", i_waitrequest, 1'b1);
        chk("mid_d_wait", d_waitrequest, 1'b1);
        chk("mid_bus_error", bus_error, 1'b0);
        idle_inputs(); waitrequest = 1'b0;
        step();
        reset = 1'b1;

        // Random traffic
        i_act = 1'b0; d_act = 1'b0; stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!reset) reset = 1'b1;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1; i_read = 1'b1; i_address = $urandom;
            end else if (!i_act) begin
                i_read = 1'b0; i_address = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                int op;
                op = $urandom_range(0, 2);
                d_act = 1'b1;
                d_read = (op != 1); d_write = (op != 0);
                d_address = $urandom; d_writedata = $urandom;
                d_byteenable = 4'($urandom_range(0, 15));
            end else if (!d_act) begin
                d_read = 1'b0; d_write = 1'b0; d_address = $urandom; d_writedata = $urandom;
            end
            if (stuck > 0) begin
                waitrequest = 1'b1; stuck--;
            end else if ($urandom_range(0, 49) == 0) begin
                waitrequest = 1'b1; stuck = 12;
            end else begin
                waitrequest = ($urandom_range(0, 9) < 4);
            end
            readdata = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0; i_act = 1'b0; d_act = 1'b0; idle_inputs();
            end
            step();
            if (e_idone) i_act = 1'b0;
            if (e_ddone) d_act = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
